// File: rtl/blink_monitor.sv
// blink_monitor: receive-side monitor for a free-running square-wave blink signal.
// It synchronises blink_in and measures, in clock cycles:
//   - the period, from one rising edge to the next
//   - the high time, from a rising edge to the falling edge that follows it
// It also counts rising edges, flags lock when two consecutive periods are
// equal, and flags stuck when no edge has been seen for STUCK_LIMIT cycles.
//
// Parameters:
//   WIDTH        width of the period, high-time and internal cycle counters
//   STUCK_LIMIT  edge-free cycles that declare the input stuck (2 .. 2^WIDTH-1)
//   EDGE_W       width of the rising-edge counter
//
// Ports:
//   clk           single clock; all logic runs on posedge clk
//   rst           synchronous active-high reset; also clears the synchroniser
//   blink_in      monitored signal; may be asynchronous to clk
//   clear         synchronous clear of all measurement state (not the synchroniser)
//   period        last complete period, in cycles
//   high_time     last complete high phase, in cycles
//   period_valid  one-cycle pulse each time period is updated
//   locked        the last two measured periods were equal
//   stuck         no edge has been seen for STUCK_LIMIT cycles
//   edge_count    rising edges seen since reset/clear; wraps silently
module blink_monitor #(
    parameter int unsigned WIDTH       = 25,
    parameter int unsigned STUCK_LIMIT = 32'h1FF_FFFF,
    parameter int unsigned EDGE_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              blink_in,
    input  logic              clear,
    output logic [WIDTH-1:0]  period,
    output logic [WIDTH-1:0]  high_time,
    output logic              period_valid,
    output logic              locked,
    output logic              stuck,
    output logic [EDGE_W-1:0] edge_count
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [WIDTH-1:0] AGE_LIMIT = WIDTH'(STUCK_LIMIT);
    localparam logic [WIDTH-1:0] AGE_TRIP  = WIDTH'(STUCK_LIMIT - 1);

    logic s1, s2, s2_d;
    logic rise, fall;

    state_t            state, state_n;
    logic [WIDTH-1:0]  cnt, cnt_n;
    logic [WIDTH-1:0]  age, age_n;
    logic [WIDTH-1:0]  period_n, high_time_n;
    logic              period_valid_n, locked_n, stuck_n;
    logic [EDGE_W-1:0] edge_count_n;
    // A previous period exists since the last IDLE, so a comparison is meaningful.
    logic              prev_ok, prev_ok_n;

    // Synchroniser and edge-detect delay; only rst clears these.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
        end else begin
            s1   <= blink_in;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    assign rise = s2 & ~s2_d;
    assign fall = ~s2 & s2_d;

    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        age_n          = age;
        period_n       = period;
        high_time_n    = high_time;
        period_valid_n = 1'b0;
        locked_n       = locked;
        stuck_n        = stuck;
        edge_count_n   = edge_count;
        prev_ok_n      = prev_ok;

        if (state != IDLE && cnt != CNT_MAX)
            cnt_n = cnt + WIDTH'(1);

        // Age saturates at the limit so a long-stuck input does not retrigger.
        if (rise || fall) begin
            age_n   = '0;
            stuck_n = 1'b0;
        end else if (age != AGE_LIMIT) begin
            age_n = age + WIDTH'(1);
        end

        if (rise) begin
            state_n      = HIGH;
            cnt_n        = WIDTH'(1);
            edge_count_n = edge_count + EDGE_W'(1);
            if (state == LOW) begin
                period_n       = cnt;
                period_valid_n = 1'b1;
                locked_n       = prev_ok && (cnt == period);
                prev_ok_n      = 1'b1;
            end
        end else if (fall) begin
            if (state == HIGH) begin
                high_time_n = cnt;
                state_n     = LOW;
            end
        end else if (age == AGE_TRIP) begin
            // Abandon the interrupted period; period/high_time keep old values.
            stuck_n   = 1'b1;
            locked_n  = 1'b0;
            state_n   = IDLE;
            cnt_n     = '0;
            prev_ok_n = 1'b0;
        end

        // clear overrides everything above, including an edge in this cycle.
        if (clear) begin
            state_n        = IDLE;
            cnt_n          = '0;
            age_n          = '0;
            period_n       = '0;
            high_time_n    = '0;
            period_valid_n = 1'b0;
            locked_n       = 1'b0;
            stuck_n        = 1'b0;
            edge_count_n   = '0;
            prev_ok_n      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            age          <= '0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            stuck        <= 1'b0;
            edge_count   <= '0;
            prev_ok      <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            age          <= age_n;
            period       <= period_n;
            high_time    <= high_time_n;
            period_valid <= period_valid_n;
            locked       <= locked_n;
            stuck        <= stuck_n;
            edge_count   <= edge_count_n;
            prev_ok      <= prev_ok_n;
        end
    end

endmodule

// File: doc/blink_monitor.md
# blink_monitor

Receive-side companion to the LED blinker: observes a free-running square-wave blink signal and measures it. Synchronises the input, measures period (rising-to-rising) and high time in clock cycles, counts rising edges, flags lock on a stable period and a stuck (edge-free) input. Used in self-test to confirm a blinker output is alive and running at its expected rate.

## Interface
- WIDTH, 25: width of the period, high-time and internal cycle counters.
- STUCK_LIMIT, 25'h1FFFFFF: edge-free cycles that declare the input stuck; legal range 2 .. 2^WIDTH-1.
- EDGE_W, 16: width of the rising-edge counter.
- clk  in  1  single clock; all logic on posedge clk.
- rst  in  1  synchronous, active-high reset.
- blink_in  in  1  monitored signal, may be asynchronous to clk.
- clear  in  1  synchronous clear of all measurement state; same effect as rst except the synchroniser flops.
- period  out  WIDTH  last complete period in cycles.
- high_time  out  WIDTH  last complete high phase in cycles.
- period_valid  out  1  one-cycle pulse when period is updated.
- locked  out  1  last two measured periods are equal.
- stuck  out  1  no edge seen for STUCK_LIMIT cycles.
- edge_count  out  EDGE_W  rising edges seen since reset/clear; wraps.

## Operation
- Two-flop synchroniser (s1, s2) plus a delay flop s2_d. rise = s2 & ~s2_d, fall = ~s2 & s2_d.
- States: IDLE, HIGH, LOW.
  - IDLE: wait for rise; on rise -> HIGH, period counter := 1, edge_count += 1; no period_valid.
  - HIGH: on fall -> LOW, high_time := cycles since the last rise (counter value).
  - LOW: on rise -> HIGH, period := counter value, period_valid pulses, edge_count += 1, counter := 1.
  - The period counter increments by 1 every cycle outside IDLE and saturates at 2^WIDTH-1. A saturated value is reported as is.
- Result: a square wave with H cycles high and L cycles low reports high_time = H and period = H+L.
- Lock: on each period_valid, locked := (new period == previous reported period). The first period after IDLE always leaves locked = 0.
- Stuck:
  - An age counter clears on any rise or fall and otherwise increments.
  - When it reaches STUCK_LIMIT, stuck := 1, locked := 0, state -> IDLE. The interrupted period is discarded; period and high_time hold their old values.
  - stuck clears on the next rise or fall. A fall just sets age := 0 in IDLE; the next rise starts a fresh measurement without period_valid.
- Simultaneous events:
  - clear or rst beats any edge in the same cycle; that edge is dropped.
  - A stuck declaration and an edge in the same cycle: the edge wins and stuck is not set.
- edge_count wraps 2^EDGE_W-1 -> 0 silently.

## Timing
- Reset/clear values: period = 0, high_time = 0, period_valid = 0, locked = 0, stuck = 0, edge_count = 0, state IDLE, counters 0. rst also zeroes s1, s2, s2_d; clear does not.
- Latency: blink_in first sampled high at edge E0. s2 = 1 after E1; rise is acted on at E2. period, period_valid and edge_count are visible after E2. Falls behave identically for high_time.
- period_valid is high exactly one cycle per accepted rise.
- Minimum resolvable phase is 1 cycle; glitches shorter than one clock may be lost by the synchroniser.
- All outputs are registered; no combinational path from blink_in.

## Test plan
- Reset then steady wave, WIDTH=8, STUCK_LIMIT=50, 10 high / 10 low: first rise gives no period_valid. From the 2nd rise on, period = 20 and high_time = 10. locked = 1 from the 3rd rise; edge_count increments per rise.
- Duty change, 5 high / 15 low after lock: high_time = 5, period = 20, locked stays 1. Then 10/20: period = 30, locked drops to 0 for one measurement, returns to 1 on the next.
- Stuck: hold blink_in low for 60 cycles after lock -> stuck = 1 exactly 50 cycles after the last fall is acted on, locked = 0, period held at 20. The next rise clears stuck with no period_valid; the following rise gives valid period.
- clear asserted in the same cycle a rise is acted on -> all outputs 0 next cycle, edge_count = 0. The next rise only starts a measurement.
- Saturation, WIDTH=4, STUCK_LIMIT=15, 12 high / 12 low: period = 15 (saturated), no stuck.
- Wrap, EDGE_W=2, 5 rising edges: edge_count sequence 1, 2, 3, 0, 1.
